// File: rtl/ebus_pkg.sv
// Shared types and constants for the EBUS I/O cycle controller.
// Buses use PDP-10 numbering, so bit 0 is the most significant.
package ebus_pkg;

  localparam int CS_W   = 7;
  localparam int FUNC_W = 3;
  localparam int DATA_W = 36;

  typedef logic [0:CS_W-1]   cs_t;
  typedef logic [0:FUNC_W-1] func_t;
  typedef logic [0:DATA_W-1] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DEMAND,
    ST_RELWAIT,
    ST_HOLD
  } ebus_state_t;

  localparam func_t CONO  = 3'o0;
  localparam func_t CONI  = 3'o1;
  localparam func_t DATAO = 3'o2;
  localparam func_t DATAI = 3'o3;

endpackage

// File: rtl/ebus_ctl_if.sv
// Request, device and EBUS signals of one controller; master is the controller
// (it masters the EBUS), slave is the requester/device environment.
interface ebus_ctl_if;
  import ebus_pkg::*;

  logic  ebusReq;
  logic  ebusReturn;
  cs_t   reqCS;
  func_t reqFunc;
  logic  reqInput;
  word_t reqData;
  logic  ebusXfer;
  word_t EBUS;

  logic  ebusGrant;
  cs_t   EBUS_CS;
  func_t EBUS_F;
  logic  ebusDemand;
  logic  EBUS_drive;
  word_t EBUS_D;
  word_t dataIn;
  logic  ebusDone;
  logic  ebusTimeout;

  modport master (
    input  ebusReq, ebusReturn, reqCS, reqFunc, reqInput, reqData, ebusXfer, EBUS,
    output ebusGrant, EBUS_CS, EBUS_F, ebusDemand, EBUS_drive, EBUS_D, dataIn,
           ebusDone, ebusTimeout
  );

  modport slave (
    output ebusReq, ebusReturn, reqCS, reqFunc, reqInput, reqData, ebusXfer, EBUS,
    input  ebusGrant, EBUS_CS, EBUS_F, ebusDemand, EBUS_drive, EBUS_D, dataIn,
           ebusDone, ebusTimeout
  );

endinterface

// File: rtl/ebus_timer.sv
// Clearable demand-phase counter; o_tc is combinational and flags the last
// permitted cycle (count == TIMEOUT_CYCLES-1) while enabled.
module ebus_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_tc      = i_en && w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ebus_ctl.sv
// EBUS I/O cycle controller: grant, setup, demand, release and hold phases.
// Demand rises SETUP_CYCLES+1 cycles after ebusReq; all outputs are registered.
module ebus_ctl
  import ebus_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic        clk,
  input logic        reset,
  ebus_ctl_if.master bus
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  ebus_state_t r_state;
  logic [SW-1:0] r_setup_cnt;
  logic        r_input;
  logic        r_grant;
  cs_t         r_ebus_cs;
  func_t       r_ebus_f;
  logic        r_demand;
  logic        r_drive;
  word_t       r_ebus_d;
  word_t       r_data_in;
  logic        r_done;
  logic        r_timeout;

  logic        w_setup_last;
  logic        w_tmr_clr;
  logic        w_tmr_en;
  logic        w_tc;

  assign w_setup_last = (r_setup_cnt == SW'(SETUP_CYCLES - 1));
  assign w_tmr_clr    = (r_state == ST_SETUP) && w_setup_last;
  assign w_tmr_en     = (r_state == ST_DEMAND);

  ebus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (reset),
    .i_clr(w_tmr_clr),
    .i_en (w_tmr_en),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_setup_cnt <= '0;
      r_input     <= 1'b0;
      r_grant     <= 1'b0;
      r_ebus_cs   <= '0;
      r_ebus_f    <= '0;
      r_demand    <= 1'b0;
      r_drive     <= 1'b0;
      r_ebus_d    <= '0;
      r_data_in   <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.ebusReq) begin
            r_state     <= ST_SETUP;
            r_setup_cnt <= '0;
            r_grant     <= 1'b1;
            r_ebus_cs   <= bus.reqCS;
            r_ebus_f    <= bus.reqFunc;
            r_input     <= bus.reqInput;
            r_drive     <= !bus.reqInput;
            r_ebus_d    <= bus.reqInput ? '0 : bus.reqData;
          end
        end
        ST_SETUP: begin
          if (w_setup_last) begin
            r_state  <= ST_DEMAND;
            r_demand <= 1'b1;
          end else begin
            r_setup_cnt <= r_setup_cnt + SW'(1);
          end
        end
        ST_DEMAND: begin
          // A transfer on the terminal cycle still counts as a normal completion.
          if (bus.ebusXfer) begin
            if (r_input) begin
              r_data_in <= bus.EBUS;
            end
            r_state  <= ST_RELWAIT;
            r_done   <= 1'b1;
            r_demand <= 1'b0;
            r_drive  <= 1'b0;
            r_ebus_d <= '0;
          end else if (w_tc) begin
            r_state   <= ST_HOLD;
            r_data_in <= '0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_demand  <= 1'b0;
            r_drive   <= 1'b0;
            r_ebus_d  <= '0;
            r_ebus_cs <= '0;
            r_ebus_f  <= '0;
          end
        end
        ST_RELWAIT: begin
          if (!bus.ebusXfer) begin
            r_state   <= ST_HOLD;
            r_ebus_cs <= '0;
            r_ebus_f  <= '0;
          end
        end
        ST_HOLD: begin
          if (bus.ebusReturn) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ebusGrant   = r_grant;
  assign bus.EBUS_CS     = r_ebus_cs;
  assign bus.EBUS_F      = r_ebus_f;
  assign bus.ebusDemand  = r_demand;
  assign bus.EBUS_drive  = r_drive;
  assign bus.EBUS_D      = r_ebus_d;
  assign bus.dataIn      = r_data_in;
  assign bus.ebusDone    = r_done;
  assign bus.ebusTimeout = r_timeout;

endmodule

// File: doc/ebus_ctl.md
EBUS_CTL -- requirements
Module: ebus_ctl

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: cycles the select and function lines are driven before demand is raised.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: cycles demand waits for transfer before the cycle aborts.
REQ-003 clk  in  1  the single block clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ebusReq  in  1  level request for one EBUS I/O cycle from the APR/PI side.
REQ-006 ebusReturn  in  1  requester releases the bus after taking ebusDone.
REQ-007 reqCS  in  [0:6]  controller select for the cycle.
REQ-008 reqFunc  in  [0:2]  EBUS function code (F0-F2).
REQ-009 reqInput  in  1  1 = CONI/DATAI (device drives data); 0 = CONO/DATAO.
REQ-010 reqData  in  [0:35]  output data for CONO/DATAO.
REQ-011 ebusXfer  in  1  device transfer acknowledge.
REQ-012 EBUS  in  [0:35]  EBUS data as driven by the device.
REQ-013 ebusGrant  out  1  bus granted to the requester.
REQ-014 EBUS_CS  out  [0:6]  controller select driven onto EBUS.
REQ-015 EBUS_F  out  [0:2]  function driven onto EBUS.
REQ-016 ebusDemand  out  1  demand line to devices.
REQ-017 EBUS_drive  out  1  enable for EBUS_D onto the data lines.
REQ-018 EBUS_D  out  [0:35]  output data.
REQ-019 dataIn  out  [0:35]  latched input data.
REQ-020 ebusDone  out  1  one-cycle pulse, cycle complete.
REQ-021 ebusTimeout  out  1  one-cycle pulse coincident with ebusDone when the cycle aborted.

Function
REQ-022 FSM states: IDLE, SETUP, DEMAND, RELWAIT, HOLD.
- IDLE: ebusReq=1 -> SETUP; register reqCS, reqFunc, reqInput and reqData; set ebusGrant=1.
REQ-023 SETUP: EBUS_CS/EBUS_F follow the registered values; EBUS_drive=1 if not input; after exactly SETUP_CYCLES cycles -> DEMAND.
REQ-024 DEMAND: ebusDemand=1; the timeout counter clears on entry and increments each cycle.
REQ-025 DEMAND with ebusXfer=1:
- if input, latch EBUS into dataIn on that edge;
- pulse ebusDone next cycle;
- go to RELWAIT.
REQ-026 DEMAND, counter reaching TIMEOUT_CYCLES-1 with ebusXfer=0:
- dataIn=0;
- pulse ebusDone and ebusTimeout;
- go to HOLD.
REQ-027 If ebusXfer and timeout coincide, ebusXfer wins: no timeout pulse.
REQ-028 RELWAIT: ebusDemand=0; EBUS_drive=0; wait for ebusXfer=0, then go to HOLD.
REQ-029 HOLD: ebusGrant stays 1 and dataIn is stable until ebusReturn=1, then -> IDLE with ebusGrant=0.
REQ-030 EBUS_CS and EBUS_F are 0 in IDLE and HOLD.
REQ-031 Request fields are ignored after capture; ebusReq falling mid-cycle does not abort the cycle.
REQ-032 ebusReturn outside HOLD is ignored; ebusReq held high in IDLE after HOLD starts a new cycle the next edge.
REQ-033 Latency: ebusReq high to ebusDemand high = SETUP_CYCLES+1 cycles.

Reset
REQ-034 While reset=1, all outputs are 0, including dataIn; FSM=IDLE; counter=0.
REQ-035 Reset mid-cycle drops demand, drive and grant asynchronously, with no done pulse.

Structure
REQ-036 A shared package ebus_pkg holds:
- the FSM state enum;
- widths for CS (7), function (3) and data (36);
- function-code constants (CONO, CONI, DATAO, DATAI).
REQ-037 One sub-module, ebus_timer, holds the clearable timeout counter and its terminal-count flag.

Verification
REQ-038 CONI: reqCS=7'o14, reqFunc=CONI, ebusReq=1; device sends ebusXfer 3 cycles after demand with EBUS=36'o123456701234 -> demand at cycle 3, dataIn=36'o123456701234, one ebusDone, no ebusTimeout.
REQ-039 DATAO: reqData=36'o777000777000 -> EBUS_drive=1 and EBUS_D=reqData from SETUP through the ebusXfer edge, then 0 in RELWAIT.
REQ-040 No device response -> ebusDone and ebusTimeout both pulse exactly 64 cycles after demand rises, dataIn=0, grant held until ebusReturn.
REQ-041 ebusXfer first asserted on the final timeout cycle -> normal completion, ebusTimeout=0.
REQ-042 Assert reset during DEMAND -> ebusDemand, ebusGrant and EBUS_drive are 0 before the next clk edge; a later ebusReq runs a clean cycle.
REQ-043 Device holds ebusXfer for 5 cycles after ack; ebusReturn pulses early in RELWAIT -> stays in RELWAIT until ebusXfer falls, then waits in HOLD for a fresh ebusReturn.
